// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, byte-enable
// patterns, the FSM state type and the legality check for a request.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic lsu_illegal(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        logic misaligned;
        bad = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = is_store;
            default:          bad = 1'b1;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3 == F3_W) && (addr_lo != 2'b00));
        return bad | (MISALIGN_TRAP & misaligned);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// outgoing access, and lane select plus sign/zero extension of the read word.
// Ports: funct3 / addr_lo (already alignment-forced lane), wdata, rdata in;
//        be, wdata_steered, rdata_ext out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be = BE_NONE;
        case (funct3)
            F3_B, F3_BU: be = BE_BYTE << addr_lo;
            F3_H, F3_HU: be = BE_HALF << {addr_lo[1], 1'b0};
            F3_W:        be = BE_WORD;
            default:     be = BE_NONE;
        endcase
    end

    always_comb begin
        wdata_steered = wdata;
        case (funct3[1:0])
            2'b00:   wdata_steered = {4{wdata[7:0]}};
            2'b01:   wdata_steered = {2{wdata[15:0]}};
            default: wdata_steered = wdata;
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext = {24'h0, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext = {16'h0, half_sel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time from execute,
// drives a single data-memory access with a timeout, and returns a one-cycle
// writeback pulse (with err on illegal or timed-out operations).
// Ports: clk, reset (sync, active-high); req_* from execute; mem_* to data
//        memory; wb_* and err to the register file; busy when not idle.
// Build option: LSU_MISALIGN_TRAP_EN (see lsu_pkg) traps misaligned H/W;
//        otherwise the low address bits are forced to natural alignment.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | mem_req held until mem_ack or timeout
// RESP   | one-cycle writeback pulse, then IDLE
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    output logic        busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cap_is_store;
    logic [2:0]       cap_funct3;
    logic [1:0]       cap_lane;
    logic [4:0]       cap_rd;

    logic [1:0]  req_lane;
    logic [2:0]  al_funct3;
    logic [1:0]  al_lane;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        req_bad;

    // Natural alignment forced on the lane; when trapping is enabled the
    // misaligned cases never reach memory, so the forced value is harmless.
    always_comb begin
        req_lane = req_addr[1:0];
        if (req_funct3[1:0] == 2'b01) begin
            req_lane[0] = 1'b0;
        end else if (req_funct3[1:0] == 2'b10) begin
            req_lane = 2'b00;
        end
    end

    assign req_bad = lsu_illegal(req_is_store, req_funct3, req_addr[1:0]);

    // One aligner serves both directions: request fields while idle, the
    // captured fields while the access is outstanding.
    assign al_funct3 = (state == S_IDLE) ? req_funct3 : cap_funct3;
    assign al_lane   = (state == S_IDLE) ? req_lane   : cap_lane;

    lsu_align u_align (
        .funct3        (al_funct3),
        .addr_lo       (al_lane),
        .wdata         (req_wdata),
        .rdata         (mem_rdata),
        .be            (al_be),
        .wdata_steered (al_wdata),
        .rdata_ext     (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            cap_is_store <= 1'b0;
            cap_funct3   <= 3'b000;
            cap_lane     <= 2'b00;
            cap_rd       <= 5'd0;
            req_ready    <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_be       <= BE_NONE;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'h0;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'h0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_is_store <= req_is_store;
                        cap_funct3   <= req_funct3;
                        cap_lane     <= req_lane;
                        cap_rd       <= req_rd;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (req_bad) begin
                            state    <= S_RESP;
                            wb_valid <= 1'b1;
                            err      <= 1'b1;
                            wb_rd    <= req_rd;
                        end else begin
                            state     <= S_ACCESS;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_is_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= req_is_store ? al_wdata : 32'h0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ack || (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
                        state     <= S_RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_wdata <= 32'h0;
                        mem_be    <= BE_NONE;
                        wb_valid  <= 1'b1;
                        wb_rd     <= cap_rd;
                        // Ack wins over a coincident timeout.
                        if (mem_ack) begin
                            wb_we   <= !cap_is_store && (cap_rd != 5'd0);
                            wb_data <= cap_is_store ? 32'h0 : al_rdata;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // samples captured by run_op
    logic        s_req, s_we, s_busy, s_ready, s_stable;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        w_valid, w_we, w_err, w_req, w_valid2, w_ready2;
    logic [4:0]  w_rd;
    logic [31:0] w_data;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err          (err),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns at cycle N+1 (after accept).
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        step();
        req_valid    = 1'b0;
    endtask

    // Full access: ack arrives after `waits` extra ACCESS cycles.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int waits, input logic [31:0] rdat);
        issue(st, f3, a, wd, rd);
        s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_be = mem_be;
        s_wdata = mem_wdata; s_busy = busy; s_ready = req_ready; s_stable = 1'b1;
        for (int i = 0; i < waits; i++) begin
            step();
            if (!mem_req || mem_we !== s_we || mem_addr !== s_addr ||
                mem_be !== s_be || mem_wdata !== s_wdata || wb_valid)
                s_stable = 1'b0;
        end
        mem_ack   = 1'b1;
        mem_rdata = rdat;
        step();
        mem_ack   = 1'b0;
        w_valid = wb_valid; w_we = wb_we; w_rd = wb_rd; w_data = wb_data;
        w_err = err; w_req = mem_req;
        step();
        w_valid2 = wb_valid; w_ready2 = req_ready;
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb", {wb_valid, wb_we, err, wb_rd, 24'(wb_data != 0)}, 32'd0);
        reset = 1'b0;
        step();

        // LW 0x100, ack on third ACCESS cycle
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 2, 32'hDEADBEEF);
        chk("lw_req", 32'(s_req), 32'd1);
        chk("lw_we", 32'(s_we), 32'd0);
        chk("lw_addr", s_addr, 32'h100);
        chk("lw_be", 32'(s_be), 32'hF);
        chk("lw_busy", 32'({s_busy, s_ready}), 32'b10);
        chk("lw_stable", 32'(s_stable), 32'd1);
        chk("lw_wbv", 32'(w_valid), 32'd1);
        chk("lw_data", w_data, 32'hDEADBEEF);
        chk("lw_we_rd", {26'h0, w_we, w_rd}, {26'h0, 1'b1, 5'd5});
        chk("lw_err", 32'(w_err), 32'd0);
        chk("lw_req_drop", 32'(w_req), 32'd0);
        chk("lw_pulse", 32'({w_valid2, w_ready2}), 32'b01);

        // LB / LBU lane 3
        run_op(1'b0, 3'b000, 32'h203, 32'h0, 5'd6, 0, 32'h80FFFFFF);
        chk("lb_addr", s_addr, 32'h200);
        chk("lb_be", 32'(s_be), 32'h8);
        chk("lb_data", w_data, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h203, 32'h0, 5'd6, 0, 32'h80FFFFFF);
        chk("lbu_data", w_data, 32'h00000080);

        // LH / LHU upper half
        run_op(1'b0, 3'b001, 32'h302, 32'h0, 5'd9, 1, 32'h80011234);
        chk("lh_data", w_data, 32'hFFFF8001);
        run_op(1'b0, 3'b101, 32'h302, 32'h0, 5'd9, 0, 32'h80011234);
        chk("lhu_data", w_data, 32'h00008001);

        // SH 0x102
        run_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd4, 1, 32'h0);
        chk("sh_we", 32'(s_we), 32'd1);
        chk("sh_be", 32'(s_be), 32'hC);
        chk("sh_wdata", s_wdata, 32'hABCDABCD);
        chk("sh_wbwe", 32'({w_valid, w_we, w_err}), 32'b100);

        // SB 0x101
        run_op(1'b1, 3'b000, 32'h101, 32'h00000055, 5'd4, 0, 32'h0);
        chk("sb_be", 32'(s_be), 32'h2);
        chk("sb_wdata", s_wdata, 32'h55555555);

        // LW to x0: no register write
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd0, 0, 32'h12345678);
        chk("lw_x0_we", 32'({w_valid, w_we}), 32'b10);

        // Misaligned LW 0x101
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h101, 32'h0, 5'd5);
        chk("mis_noreq", 32'(mem_req), 32'd0);
        chk("mis_err", 32'({wb_valid, err, wb_we}), 32'b110);
        step();
`else
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd5, 0, 32'hCAFEF00D);
        chk("mis_addr", s_addr, 32'h100);
        chk("mis_be", 32'(s_be), 32'hF);
        chk("mis_err", 32'({w_valid, w_err}), 32'b10);
        chk("mis_data", w_data, 32'hCAFEF00D);
`endif

        // Illegal: store with BU code, load with funct3 011
        issue(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, 5'd3);
        chk("ill_sbu_noreq", 32'(mem_req), 32'd0);
        chk("ill_sbu", 32'({wb_valid, err, wb_we}), 32'b110);
        chk("ill_sbu_data", wb_data, 32'h0);
        step();
        chk("ill_sbu_idle", 32'({req_ready, busy, wb_valid}), 32'b100);
        issue(1'b0, 3'b011, 32'h40, 32'h0, 5'd3);
        chk("ill_f3", 32'({mem_req, wb_valid, err}), 32'b011);
        step();

        // Timeout: no ack
        issue(1'b0, 3'b010, 32'h40, 32'h0, 5'd7);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_wb", 32'({wb_valid, err, wb_we}), 32'b110);
        chk("to_data", wb_data, 32'h0);
        step();

        // Ack on the 16th cycle beats the timeout
        issue(1'b0, 3'b010, 32'h44, 32'h0, 5'd3);
        repeat (15) step();
        chk("to16_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        step();
        mem_ack = 1'b0;
        chk("to16_wb", 32'({wb_valid, err, wb_we}), 32'b101);
        chk("to16_data", wb_data, 32'h11223344);
        step();

        // Reset during the 2nd ACCESS cycle
        issue(1'b0, 3'b010, 32'h80, 32'h0, 5'd8);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstacc_req", 32'(mem_req), 32'd0);
        chk("rstacc_ready", 32'({req_ready, busy}), 32'b10);
        n = 0;
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (wb_valid) n++;
            step();
        end
        mem_ack = 1'b0;
        chk("rstacc_nowb", 32'(n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
